obstacle_field_controller: RTL

- Manages a pool of N_OBST independent falling obstacles for the game screen; generalises the single-obstacle controller.
- Accepts spawn requests through a valid/ready handshake and allocates each request to the lowest free slot.
- Advances every active obstacle downward on an internal movement tick, at a per-type speed.
- Retires obstacles that pass the bottom edge and keeps a saturating passed-obstacle count for the score logic.
- Outputs feed the HDMI sprite renderer and the collision checker.

---
 rtl/obstacle_field_controller.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/obstacle_field_controller.sv
// Pool of N_OBST falling obstacles: lowest-free-slot spawning over valid/ready,
// per-type fall speed on a divided movement tick, retire accounting for scoring.
module obstacle_field_controller #(
  parameter int N_OBST   = 4,
  parameter int W        = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int SIZE_X   = 32,
  parameter int SIZE_Y   = 32,
  parameter int STEP     = 4,
  parameter int TICK_DIV = 833333
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  pause,
  input  logic                  clear,
  input  logic                  spawn_valid,
  output logic                  spawn_ready,
  input  logic [W-1:0]          spawn_x,
  input  logic [1:0]            spawn_type,
  output logic [N_OBST-1:0]     obstacle_active,
  output logic [N_OBST*W-1:0]   obstacle_x,
  output logic [N_OBST*W-1:0]   obstacle_y,
  output logic [2*N_OBST-1:0]   obstacle_type,
  output logic                  despawn_pulse,
  output logic [7:0]            passed_count
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = (N_OBST > 1) ? $clog2(N_OBST) : 1;
  localparam int RET_W = $clog2(N_OBST + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [W-1:0]     X_MAX    = W'(SCREEN_W - SIZE_X);
  localparam logic [W+1:0]     Y_MAX    = (W+2)'(SCREEN_H - SIZE_Y);

  function automatic logic [W-1:0] clamp_x(input logic [W-1:0] xin);
    return (xin > X_MAX) ? X_MAX : xin;
  endfunction

  function automatic logic [W+1:0] speed_of(input logic [1:0] t);
    logic [W+1:0] mult;
    mult = {{W{1'b0}}, t} + (W+2)'(1);
    return mult * (W+2)'(STEP);
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [RET_W-1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + 9'(b);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [CNT_W-1:0]  tick_cnt;
  logic              tick;

  logic [N_OBST-1:0] active_p1;
  logic [W-1:0]      x_p1    [N_OBST];
  logic [W-1:0]      y_p1    [N_OBST];
  logic [1:0]        type_p1 [N_OBST];

  logic [N_OBST-1:0] active_nxt;
  logic [W-1:0]      x_nxt    [N_OBST];
  logic [W-1:0]      y_nxt    [N_OBST];
  logic [1:0]        type_nxt [N_OBST];
  logic [RET_W-1:0]  retire_cnt;
  logic [IDX_W-1:0]  free_idx;
  logic              spawn_fire;

  // Movement tick divider; pause freezes the phase
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (!pause) begin
      tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + CNT_W'(1);
    end
  end

  assign tick = ~pause & (tick_cnt == CNT_LAST);

  always_comb begin
    free_idx = '0;
    for (int i = N_OBST - 1; i >= 0; i--) begin
      if (!active_p1[i]) free_idx = IDX_W'(i);
    end
  end

  // Ready looks only at registered occupancy, so a slot freed this tick is reusable next cycle
  assign spawn_ready = ~pause & ~clear & ~(&active_p1);
  assign spawn_fire  = spawn_valid & spawn_ready;

  always_comb begin
    logic [W+1:0] ny;
    ny         = '0;
    active_nxt = active_p1;
    retire_cnt = '0;
    for (int i = 0; i < N_OBST; i++) begin
      x_nxt[i]    = x_p1[i];
      y_nxt[i]    = y_p1[i];
      type_nxt[i] = type_p1[i];
      if (tick && active_p1[i] && !clear) begin
        ny = {2'b00, y_p1[i]} + speed_of(type_p1[i]);
        if (ny > Y_MAX) begin
          active_nxt[i] = 1'b0;
          retire_cnt    = retire_cnt + RET_W'(1);
        end else begin
          y_nxt[i] = ny[W-1:0];
        end
      end
      // A freshly spawned slot was inactive, so the tick above never touched it
      if (spawn_fire && free_idx == IDX_W'(i)) begin
        active_nxt[i] = 1'b1;
        x_nxt[i]      = clamp_x(spawn_x);
        y_nxt[i]      = '0;
        type_nxt[i]   = spawn_type;
      end
    end
    if (clear) active_nxt = '0;
  end

  // Slot state and score registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      active_p1     <= '0;
      despawn_pulse <= 1'b0;
      passed_count  <= '0;
      for (int i = 0; i < N_OBST; i++) begin
        x_p1[i]    <= '0;
        y_p1[i]    <= '0;
        type_p1[i] <= '0;
      end
    end else begin
      active_p1     <= active_nxt;
      despawn_pulse <= (retire_cnt != '0);
      passed_count  <= sat_add(passed_count, retire_cnt);
      for (int i = 0; i < N_OBST; i++) begin
        x_p1[i]    <= x_nxt[i];
        y_p1[i]    <= y_nxt[i];
        type_p1[i] <= type_nxt[i];
      end
    end
  end

  assign obstacle_active = active_p1;

  for (genvar g = 0; g < N_OBST; g++) begin : g_pack
    assign obstacle_x[g*W +: W]    = x_p1[g];
    assign obstacle_y[g*W +: W]    = y_p1[g];
    assign obstacle_type[g*2 +: 2] = type_p1[g];
  end

endmodule
